dual_prod_accum: RTL and testbench

DUAL_PROD_ACCUM -- requirements
Module: dual_prod_accum

---
 rtl/dual_prod_accum.sv | 136 +++++++++++++
 tb/tb_dual_prod_accum.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_prod_accum.sv
// dual_prod_accum
//   Two-lane accumulator behind a dual multiplier. Each lane adds its signed
//   17-bit product into a wrapping ACC_W-bit accumulator. At the end of a
//   window the two sums go to a requantisation (RQ) stage. That stage rounds,
//   shifts, optionally applies ReLU and saturates to int8. The result then
//   leaves through a single output register with a valid/ready handshake.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   i_valid, i_last        product-pair beat and end-of-window marker
//   prod_ac, prod_bc       signed 17-bit products for lanes a and b
//   cfg_bias_a/b           per-lane bias loaded on the first beat of a window
//   cfg_shift, cfg_relu    requantisation shift and ReLU enable, captured at i_last
//   stall_req              asks upstream to pause while both stages are blocked
//   o_valid, o_ready       output handshake
//   o_a, o_b, o_sat        int8 results and per-lane saturation flags
//   err_overrun            sticky: a finished window was dropped
module dual_prod_accum #(
  parameter int ACC_W = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_valid,
  input  logic                    i_last,
  input  logic signed [16:0]      prod_ac,
  input  logic signed [16:0]      prod_bc,
  input  logic signed [ACC_W-1:0] cfg_bias_a,
  input  logic signed [ACC_W-1:0] cfg_bias_b,
  input  logic [4:0]              cfg_shift,
  input  logic                    cfg_relu,
  output logic                    stall_req,
  output logic                    o_valid,
  input  logic                    o_ready,
  output logic signed [7:0]       o_a,
  output logic signed [7:0]       o_b,
  output logic [1:0]              o_sat,
  output logic                    err_overrun
);

  localparam int RW = ACC_W + 1;
  localparam logic signed [RW-1:0] SAT_MAX = RW'(127);
  localparam logic signed [RW-1:0] SAT_MIN = RW'(-128);

  logic signed [ACC_W-1:0] acc_a, acc_b;
  logic signed [ACC_W-1:0] ext_ac, ext_bc;
  logic signed [ACC_W-1:0] sum_a, sum_b;
  logic                    first;

  logic                    rq_valid;
  logic signed [ACC_W-1:0] rq_sum_a, rq_sum_b;
  logic [4:0]              rq_shift;
  logic                    rq_relu;

  logic       rq_adv, win_end, rq_load;
  logic [8:0] rq_res_a, rq_res_b;

  // The returned value is {sat, int8}. The extra bit of headroom holds the
  // rounding add. ReLU is applied before saturation, so a value clamped by
  // ReLU alone does not set the sat flag.
  function automatic logic [8:0] requant(input logic signed [ACC_W-1:0] sum,
                                         input logic [4:0] sh,
                                         input logic relu);
    logic signed [RW-1:0] rnd;
    logic signed [RW-1:0] r;
    logic [8:0]           res;
    rnd = (sh == 5'd0) ? '0 : (RW'(1) << (sh - 5'd1));
    r   = ($signed({sum[ACC_W-1], sum}) + rnd) >>> sh;
    if (relu && r[RW-1]) r = '0;
    if (r > SAT_MAX)      res = {1'b1, 8'h7f};
    else if (r < SAT_MIN) res = {1'b1, 8'h80};
    else                  res = {1'b0, r[7:0]};
    return res;
  endfunction

  assign ext_ac = {{(ACC_W-17){prod_ac[16]}}, prod_ac};
  assign ext_bc = {{(ACC_W-17){prod_bc[16]}}, prod_bc};
  assign sum_a  = (first ? cfg_bias_a : acc_a) + ext_ac;
  assign sum_b  = (first ? cfg_bias_b : acc_b) + ext_bc;

  assign rq_adv    = rq_valid && (!o_valid || o_ready);
  assign win_end   = i_valid && i_last;
  // RQ can take a new sum if it is empty or is emptying in this cycle.
  assign rq_load   = win_end && (!rq_valid || rq_adv);
  assign stall_req = rq_valid && o_valid && !o_ready;

  assign rq_res_a = requant(rq_sum_a, rq_shift, rq_relu);
  assign rq_res_b = requant(rq_sum_b, rq_shift, rq_relu);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_a       <= '0;
      acc_b       <= '0;
      first       <= 1'b1;
      rq_valid    <= 1'b0;
      rq_sum_a    <= '0;
      rq_sum_b    <= '0;
      rq_shift    <= '0;
      rq_relu     <= 1'b0;
      o_valid     <= 1'b0;
      o_a         <= '0;
      o_b         <= '0;
      o_sat       <= '0;
      err_overrun <= 1'b0;
    end else begin
      // The accumulator restarts after every last beat, even when the result
      // of that window is dropped.
      if (i_valid) begin
        acc_a <= sum_a;
        acc_b <= sum_b;
        first <= i_last;
      end

      if (rq_load) begin
        rq_valid <= 1'b1;
        rq_sum_a <= sum_a;
        rq_sum_b <= sum_b;
        rq_shift <= cfg_shift;
        rq_relu  <= cfg_relu;
      end else if (rq_adv) begin
        rq_valid <= 1'b0;
      end

      if (win_end && !rq_load) err_overrun <= 1'b1;

      if (rq_adv) begin
        o_valid <= 1'b1;
        o_a     <= rq_res_a[7:0];
        o_b     <= rq_res_b[7:0];
        o_sat   <= {rq_res_b[8], rq_res_a[8]};
      end else if (o_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dual_prod_accum.sv
module tb_dual_prod_accum;

  localparam int ACC_W = 24;

  logic                    clk;
  logic                    rst_n;
  logic                    i_valid;
  logic                    i_last;
  logic signed [16:0]      prod_ac;
  logic signed [16:0]      prod_bc;
  logic signed [ACC_W-1:0] cfg_bias_a;
  logic signed [ACC_W-1:0] cfg_bias_b;
  logic [4:0]              cfg_shift;
  logic                    cfg_relu;
  logic                    stall_req;
  logic                    o_valid;
  logic                    o_ready;
  logic signed [7:0]       o_a;
  logic signed [7:0]       o_b;
  logic [1:0]              o_sat;
  logic                    err_overrun;

  dual_prod_accum #(.ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_last(i_last),
    .prod_ac(prod_ac), .prod_bc(prod_bc),
    .cfg_bias_a(cfg_bias_a), .cfg_bias_b(cfg_bias_b),
    .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
    .stall_req(stall_req), .o_valid(o_valid), .o_ready(o_ready),
    .o_a(o_a), .o_b(o_b), .o_sat(o_sat), .err_overrun(err_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  function automatic void chk(string nm, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural reference model ----------------
  // The model keeps results in flight as a queue. A result can be shown from
  // two cycles after its last beat. A new window is lost when two results
  // are already in flight and the consumer is not ready.
  typedef struct {
    longint a;
    longint b;
    longint sat;
    longint avail;
  } res_t;

  res_t   q[$];
  longint m_acc_a, m_acc_b, cyc;
  bit     m_first, m_err;

  function automatic longint wrapw(longint v);
    longint m;
    m = longint'(1) << ACC_W;
    v = v & (m - 1);
    if (v >= m / 2) v -= m;
    return v;
  endfunction

  // Rounding and shift give floor((s + half) / 2^sh), then ReLU.
  function automatic longint rq_raw(longint s, int sh, bit relu);
    longint r;
    r = s + ((sh != 0) ? (longint'(1) << (sh - 1)) : 0);
    r = r >>> sh;
    if (relu && r < 0) r = 0;
    return r;
  endfunction

  function automatic longint clamp8(longint r);
    return (r > 127) ? 127 : ((r < -128) ? -128 : r);
  endfunction

  always @(negedge clk) begin
    bit     exp_v;
    longint sa, sb, ra, rb;
    res_t   e;
    if (!rst_n) begin
      chk("rst o_valid", o_valid, 0);
      chk("rst o_a", o_a, 0);
      chk("rst o_b", o_b, 0);
      chk("rst o_sat", o_sat, 0);
      chk("rst err", err_overrun, 0);
      chk("rst stall", stall_req, 0);
      q.delete();
      m_acc_a = 0; m_acc_b = 0; m_first = 1; m_err = 0;
    end else begin
      exp_v = (q.size() > 0) && (q[0].avail <= cyc);
      chk("o_valid", o_valid, exp_v);
      if (exp_v) begin
        chk("o_a", o_a, q[0].a);
        chk("o_b", o_b, q[0].b);
        chk("o_sat", o_sat, q[0].sat);
      end
      chk("stall_req", stall_req, (q.size() == 2) && !o_ready);
      chk("err_overrun", err_overrun, m_err);

      if (o_ready && exp_v) void'(q.pop_front());
      if (i_valid) begin
        sa = wrapw((m_first ? longint'(cfg_bias_a) : m_acc_a) + longint'(prod_ac));
        sb = wrapw((m_first ? longint'(cfg_bias_b) : m_acc_b) + longint'(prod_bc));
        m_acc_a = sa; m_acc_b = sb; m_first = i_last;
        if (i_last) begin
          if (q.size() == 2) m_err = 1;
          else begin
            ra = rq_raw(sa, int'(cfg_shift), cfg_relu);
            rb = rq_raw(sb, int'(cfg_shift), cfg_relu);
            e.a = clamp8(ra);
            e.b = clamp8(rb);
            e.sat = ((clamp8(rb) != rb) ? 2 : 0) + ((clamp8(ra) != ra) ? 1 : 0);
            e.avail = cyc + 2;
            q.push_back(e);
          end
        end
      end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic beat(input bit v, input bit l, input int a, input int b);
    i_valid = v;
    i_last  = l;
    prod_ac = 17'(a);
    prod_bc = 17'(b);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_last  = 1'b0;
    @(posedge clk); #1;
    rst_n   = 1'b1;
  endtask

  initial begin
    cyc = 0; m_first = 1; m_err = 0; m_acc_a = 0; m_acc_b = 0;
    rst_n = 1'b0; i_valid = 0; i_last = 0; prod_ac = '0; prod_bc = '0;
    cfg_bias_a = '0; cfg_bias_b = '0; cfg_shift = '0; cfg_relu = 0; o_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset o_valid", o_valid, 0);
    chk("reset err", err_overrun, 0);
    rst_n = 1'b1;

    // multi-beat window, latency and saturation of lane b
    cfg_bias_a = 10; cfg_bias_b = 0; cfg_shift = 2; cfg_relu = 0;
    beat(1, 0, 100, -300);
    beat(1, 0, 200, -300);
    beat(1, 1, -50, -300);
    chk("lat T+1 o_valid", o_valid, 0);
    beat(0, 0, 0, 0);
    chk("lat T+2 o_valid", o_valid, 1);
    chk("win3 o_a", o_a, 65);
    chk("win3 o_b", o_b, -128);
    chk("win3 o_sat", o_sat, 2);
    beat(0, 0, 0, 0);

    // single-beat window, both lanes saturate
    do_reset();
    cfg_bias_a = 0; cfg_shift = 0;
    beat(1, 1, 32385, -32640);
    beat(0, 0, 0, 0);
    chk("single o_a", o_a, 127);
    chk("single o_b", o_b, -128);
    chk("single o_sat", o_sat, 3);

    // ReLU clamp is not saturation
    cfg_relu = 1;
    beat(1, 1, -40, 37);
    beat(0, 0, 0, 0);
    chk("relu o_a", o_a, 0);
    chk("relu o_b", o_b, 37);
    chk("relu o_sat", o_sat, 0);
    cfg_relu = 0;
    beat(0, 0, 0, 0);

    // backpressure, stall and overrun
    do_reset();
    o_ready = 0;
    beat(1, 1, 1, 1);
    beat(1, 1, 2, 2);
    chk("ovr stall", stall_req, 1);
    beat(1, 1, 3, 3);
    chk("ovr err", err_overrun, 1);
    i_valid = 0; i_last = 0; o_ready = 1;
    #1;
    chk("ovr out1 valid", o_valid, 1);
    chk("ovr out1", o_a, 1);
    beat(0, 0, 0, 0);
    chk("ovr out2 valid", o_valid, 1);
    chk("ovr out2", o_a, 2);
    beat(0, 0, 0, 0);
    chk("ovr no out3", o_valid, 0);
    chk("ovr err sticky", err_overrun, 1);

    // reset mid-window discards the partial sum
    do_reset();
    beat(1, 0, 50, 50);
    beat(1, 0, 50, 50);
    do_reset();
    chk("rstwin idle", o_valid, 0);
    beat(1, 1, 5, 5);
    beat(0, 0, 0, 0);
    chk("rstwin valid", o_valid, 1);
    chk("rstwin o_a", o_a, 5);
    beat(0, 0, 0, 0);
    chk("rstwin no stale", o_valid, 0);

    // i_last on every cycle, full throughput
    do_reset();
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) beat(1, 1, i + 1, 0);
      else       beat(0, 0, 0, 0);
      if (i >= 1) begin
        chk("stream valid", o_valid, 1);
        chk("stream o_a", o_a, i);
      end
    end
    beat(0, 0, 0, 0);

    // randomized traffic
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      rst_n = ($urandom_range(0, 399) != 0);
      o_ready = ($urandom_range(0, 9) < 6);
      cfg_relu = 1'($urandom_range(0, 1));
      cfg_shift = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 8))
                                              : 5'($urandom_range(0, ACC_W - 1));
      if ($urandom_range(0, 3) == 0) begin
        cfg_bias_a = ACC_W'($urandom);
        cfg_bias_b = ACC_W'($urandom);
      end else begin
        cfg_bias_a = ACC_W'($signed($urandom_range(0, 400)) - 200);
        cfg_bias_b = ACC_W'($signed($urandom_range(0, 400)) - 200);
      end
      if ($urandom_range(0, 1) != 0)
        beat($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
             int'($urandom_range(0, 400)) - 200, int'($urandom_range(0, 400)) - 200);
      else
        beat($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
             int'($urandom), int'($urandom));
    end
    rst_n = 1;
    o_ready = 1;
    repeat (5) beat(0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
